// File: rtl/sram_mem_ctrl_if.sv
// MEM-stage request/response bundle plus the 16-bit SRAM pins.
// The slave modport is the controller; the master modport is the pipeline and SRAM side.
interface sram_mem_ctrl_if;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] addr;
  logic [31:0] st_val;
  logic [31:0] rd_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;

  modport slave (
    input  mem_read_en, mem_write_en, addr, st_val, sram_dq_in,
    output rd_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );

  modport master (
    output mem_read_en, mem_write_en, addr, st_val, sram_dq_in,
    input  rd_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );
endinterface

// File: rtl/sram_mem_ctrl.sv
// Splits a 32-bit MEM-stage access into two multi-cycle 16-bit SRAM transactions
// (low half, then high half) and stalls the pipeline through ready.
module sram_mem_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] ADDR_BASE   = 32'd1024
) (
  input  logic           clk,
  input  logic           rst,
  sram_mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [16:0] word_q;
  logic [31:0] st_q;
  logic        wr_q;
  logic [31:0] rd_q;
  logic [17:0] sram_addr_q;
  logic [15:0] dq_out_q;
  logic        dq_oe_q;
  logic        we_n_q;

  logic        req_d;
  logic [31:0] offset_d;
  logic [16:0] word_d;
  logic        last_d;

  assign req_d    = bus.mem_read_en | bus.mem_write_en;
  assign offset_d = bus.addr - ADDR_BASE;
  // Word index wraps modulo 2^17; addresses below the base simply alias.
  assign word_d   = offset_d[18:2];
  assign last_d   = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      word_q      <= '0;
      st_q        <= '0;
      wr_q        <= 1'b0;
      rd_q        <= '0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      we_n_q      <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_d) begin
            word_q      <= word_d;
            st_q        <= bus.st_val;
            wr_q        <= bus.mem_write_en;
            cnt_q       <= '0;
            state_q     <= LOW;
            // Bus outputs are registered, so the low-half phase is set up here.
            sram_addr_q <= {word_d, 1'b0};
            dq_out_q    <= bus.st_val[15:0];
            dq_oe_q     <= bus.mem_write_en;
            we_n_q      <= ~bus.mem_write_en;
          end
        end
        LOW: begin
          if (last_d) begin
            cnt_q       <= '0;
            state_q     <= HIGH;
            sram_addr_q <= {word_q, 1'b1};
            dq_out_q    <= st_q[31:16];
            if (!wr_q) rd_q[15:0] <= bus.sram_dq_in;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        HIGH: begin
          if (last_d) begin
            cnt_q   <= '0;
            state_q <= DONE;
            dq_oe_q <= 1'b0;
            we_n_q  <= 1'b1;
            if (!wr_q) rd_q[31:16] <= bus.sram_dq_in;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ready       = ((state_q == IDLE) && !req_d) || (state_q == DONE);
  assign bus.rd_data     = rd_q;
  assign bus.sram_addr   = sram_addr_q;
  assign bus.sram_dq_out = dq_out_q;
  assign bus.sram_dq_oe  = dq_oe_q;
  assign bus.sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Scoreboard bench: the driver pushes expected results from a word-level memory model,
// a negedge monitor pops one entry per completed access and checks bus activity and data.
module tb_sram_mem_ctrl;
  localparam int W = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sram_mem_ctrl_if bus();

  sram_mem_ctrl #(.WAIT_CYCLES(W), .ADDR_BASE(32'd1024)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          is_wr;
    logic [31:0] rd;
    logic [17:0] lo;
    logic [15:0] dlo;
    logic [15:0] dhi;
  } exp_t;

  exp_t exp_q[$];

  // Power-up contents of the SRAM, shared by the device model and the reference.
  function automatic logic [15:0] bg(logic [17:0] a);
    return 16'(32'(a) * 13 + 7);
  endfunction

  // SRAM device model
  bit [15:0] dev_mem [0:262143];
  bit        dev_wr  [0:262143];

  always @(posedge clk) begin
    if (!bus.sram_we_n) begin
      dev_mem[bus.sram_addr] <= bus.sram_dq_out;
      dev_wr[bus.sram_addr]  <= 1'b1;
    end
  end

  assign bus.sram_dq_in = dev_wr[bus.sram_addr] ? dev_mem[bus.sram_addr] : bg(bus.sram_addr);

  // Reference model: half-word memory plus the last loaded word
  bit [15:0]   ref_mem [0:262143];
  bit          ref_wr  [0:262143];
  logic [31:0] ref_rd = 32'd0;

  function automatic logic [15:0] ref_read(logic [17:0] a);
    return ref_wr[a] ? ref_mem[a] : bg(a);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end
  endtask

  // Monitor
  initial begin
    int busy;
    int we_cnt;
    int oe_cnt;
    logic [17:0] o_lo;
    logic [17:0] o_hi;
    logic [15:0] o_dlo;
    logic [15:0] o_dhi;
    exp_t e;
    busy = 0; we_cnt = 0; oe_cnt = 0;
    o_lo = '0; o_hi = '0; o_dlo = '0; o_dhi = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy = 0; we_cnt = 0; oe_cnt = 0;
      end else if (!bus.ready) begin
        if (busy == 1) begin
          o_lo  = bus.sram_addr;
          o_dlo = bus.sram_dq_out;
        end
        if (busy == W + 1) begin
          o_hi  = bus.sram_addr;
          o_dhi = bus.sram_dq_out;
        end
        if (!bus.sram_we_n) we_cnt++;
        if (bus.sram_dq_oe) oe_cnt++;
        busy++;
      end else if (busy > 0) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_underflow: got access done, want none pending");
        end else begin
          e = exp_q.pop_front();
          check("busy_cycles", 32'(busy), 32'(2 * W + 1));
          check("rd_data", bus.rd_data, e.rd);
          check("addr_low", 32'(o_lo), 32'(e.lo));
          check("addr_high", 32'(o_hi), 32'(e.lo | 18'd1));
          check("we_cycles", 32'(we_cnt), e.is_wr ? 32'(2 * W) : 32'd0);
          check("oe_cycles", 32'(oe_cnt), e.is_wr ? 32'(2 * W) : 32'd0);
          check("done_we_n", 32'(bus.sram_we_n), 32'd1);
          if (e.is_wr) begin
            check("dq_low", 32'(o_dlo), 32'(e.dlo));
            check("dq_high", 32'(o_dhi), 32'(e.dhi));
          end
          $display("txn %s lo=%05h rd_data=%08h busy=%0d", e.is_wr ? "WR" : "RD", o_lo, bus.rd_data, busy);
        end
        busy = 0; we_cnt = 0; oe_cnt = 0;
      end
    end
  end

  // Caller is positioned 1 time unit after a rising edge with the controller idle.
  task automatic access(bit rd, bit wr, logic [31:0] a, logic [31:0] st);
    exp_t e;
    logic [31:0] off;
    logic [17:0] lo;
    int n;
    off = a - 32'd1024;
    lo  = {off[18:2], 1'b0};
    if (wr) begin
      ref_mem[lo] = st[15:0];          ref_wr[lo] = 1'b1;
      ref_mem[lo | 18'd1] = st[31:16]; ref_wr[lo | 18'd1] = 1'b1;
    end else begin
      ref_rd = {ref_read(lo | 18'd1), ref_read(lo)};
    end
    e.is_wr = wr; e.rd = ref_rd; e.lo = lo; e.dlo = st[15:0]; e.dhi = st[31:16];
    exp_q.push_back(e);
    bus.mem_read_en  = rd;
    bus.mem_write_en = wr;
    bus.addr         = a;
    bus.st_val       = st;
    n = 0;
    @(negedge clk);
    while (!bus.ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) begin
      total++;
      bad++;
      $display("FAIL timeout: got ready=0 after %0d cycles, want 1", n);
    end
    @(posedge clk);
    #1;
    bus.mem_read_en  = 1'b0;
    bus.mem_write_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] st;
    logic [31:0] a;
    int kind;
    bus.mem_read_en  = 1'b0;
    bus.mem_write_en = 1'b0;
    bus.addr         = 32'd0;
    bus.st_val       = 32'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_we_n", 32'(bus.sram_we_n), 32'd1);
    check("rst_oe", 32'(bus.sram_dq_oe), 32'd0);
    check("rst_rd_data", bus.rd_data, 32'd0);
    @(posedge clk);
    #1;

    access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'd1032, 32'd0);
    access(1'b1, 1'b0, 32'd1032, 32'd0);
    access(1'b0, 1'b1, 32'd1036, 32'h12345678);
    access(1'b1, 1'b1, 32'd1024, 32'hCAFEF00D);
    access(1'b1, 1'b0, 32'd1024, 32'd0);
    access(1'b0, 1'b1, 32'd1020, 32'hA5A55A5A);
    access(1'b1, 1'b0, 32'd1021, 32'd0);

    // Reset in the middle of a write's high phase
    st = 32'h0BADC0DE;
    bus.mem_write_en = 1'b1;
    bus.addr         = 32'd1100;
    bus.st_val       = st;
    repeat (W + 1) @(posedge clk);
    #2;
    rst = 1'b1;
    bus.mem_write_en = 1'b0;
    #1;
    check("mid_rst_we_n", 32'(bus.sram_we_n), 32'd1);
    check("mid_rst_oe", 32'(bus.sram_dq_oe), 32'd0);
    check("mid_rst_ready", 32'(bus.ready), 32'd1);
    check("mid_rst_rd_data", bus.rd_data, 32'd0);
    check("mid_rst_addr", 32'(bus.sram_addr), 32'd0);
    ref_mem[18'd38] = st[15:0];
    ref_wr[18'd38]  = 1'b1;
    ref_rd = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_we_n", 32'(bus.sram_we_n), 32'd1);
      check("post_rst_oe", 32'(bus.sram_dq_oe), 32'd0);
    end
    @(posedge clk);
    #1;
    access(1'b0, 1'b1, 32'd1028, 32'h00FF00FF);
    access(1'b1, 1'b0, 32'd1100, 32'd0);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      a    = 32'd1024 + 32'($urandom_range(0, 63));
      st   = $urandom;
      access(kind != 1, kind != 0, a, st);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sram_mem_ctrl.md
Name: sram_mem_ctrl

Overview:
- Sequences MEM-stage data accesses onto an external 16-bit, multi-cycle SRAM.
- The MEM stage presents a 32-bit word request (from the EXE/MEM pipeline register outputs). The block performs two half-word SRAM transactions and returns read data.
- While an access is in flight it deasserts ready; the pipeline drives every pipeline register's freeze input from ~ready.

Parameters:
WAIT_CYCLES, 2, SRAM cycles per half-word transaction; legal range 1..15
ADDR_BASE, 1024, byte address mapped to SRAM half-word 0

Ports:
clk  input  1  clock
rst  input  1  reset
mem_read_en  input  1  read request, held stable by the frozen pipeline
mem_write_en  input  1  write request, held stable by the frozen pipeline
addr  input  32  byte address (ALU result)
st_val  input  32  store data
rd_data  output  32  loaded word
ready  output  1  1 = no access in flight; pipeline may advance
sram_addr  output  18  SRAM half-word address
sram_dq_out  output  16  SRAM write data
sram_dq_in  input  16  SRAM read data
sram_dq_oe  output  1  1 = controller drives the SRAM data bus
sram_we_n  output  1  SRAM write strobe, active low

Behaviour:
- Reset (asynchronous, mid-operation included):
  - State goes to IDLE; counter = 0; captured address and data = 0.
  - rd_data = 0, sram_addr = 0, sram_dq_out = 0, sram_dq_oe = 0, sram_we_n = 1.
  - ready = 1 unless a request is present (ready is combinational; see below).
- Request: req = mem_read_en | mem_write_en.
  - If both are asserted, it is treated as a write; no read data is captured.
- Address mapping: word = (addr - ADDR_BASE) >> 2, truncated to 17 bits (modulo wrap, no error flag). Low half = {word, 0}; high half = {word, 1}.
- States: IDLE, LOW, HIGH, DONE.
  - IDLE:
    - If req: capture word, st_val and write flag; counter = 0; go to LOW.
    - Else: stay in IDLE.
  - LOW:
    - sram_addr = low half.
    - Counter increments each cycle.
    - When counter == WAIT_CYCLES-1: counter = 0, go to HIGH.
  - HIGH:
    - sram_addr = high half.
    - Same counter rule as LOW; on terminal count go to DONE.
  - DONE: one cycle only, then IDLE unconditionally.
- Write access:
  - In LOW/HIGH: sram_dq_oe = 1, sram_we_n = 0 for every cycle of the phase.
  - sram_dq_out = st_val[15:0] in LOW, st_val[31:16] in HIGH.
- Read access:
  - In LOW/HIGH: sram_dq_oe = 0, sram_we_n = 1.
  - sram_dq_in is sampled on the terminal-count cycle of each phase: LOW into rd_data[15:0], HIGH into rd_data[31:16].
- Outside LOW/HIGH: sram_we_n = 1, sram_dq_oe = 0; sram_addr holds its last value.
- rd_data holds until the next read completes; writes never change it.
- ready = (state == IDLE && !req) || state == DONE, combinational.
- Latency: request first seen in IDLE at cycle 0.
  - ready = 0 for cycles 0..2*WAIT_CYCLES; ready = 1 in cycle 2*WAIT_CYCLES+1 (DONE).
  - rd_data is valid in DONE.
  - W=2: five frozen cycles; ready high in cycle 5.
- Back-to-back requests:
  - The pipeline advances at the end of DONE.
  - A new request seen in the following IDLE cycle starts immediately; no extra bubble beyond that IDLE cycle.
- Request inputs changing while in LOW/HIGH/DONE are ignored; captured values are used.

Test Plan:
- Reset with rst=1, then release, no request → ready=1, sram_we_n=1, sram_dq_oe=0, rd_data=0.
- W=2, write addr=1032, st_val=0xDEADBEEF → sram_addr=4 with dq_out=0xBEEF and we_n=0 for 2 cycles; then sram_addr=5 with dq_out=0xDEAD for 2 cycles; ready=0 cycles 0-4, ready=1 cycle 5.
- Read addr=1032, SRAM model returns 0xBEEF at address 4 and 0xDEAD at address 5 → rd_data=0xDEADBEEF in DONE; sram_we_n=1 and dq_oe=0 throughout.
- Read followed immediately by write to addr=1036 → second access begins one cycle after DONE (sram_addr=6); rd_data unchanged by the write.
- Assert rst during HIGH of a write → sram_we_n=1, dq_oe=0, state IDLE at once; no further SRAM activity after release without a request.
- mem_read_en=mem_write_en=1, addr=1024 → write performed at sram_addr 0/1; rd_data unchanged; ready high after 2*W+1 cycles.
